// File: rtl/seq_chk_pkg.sv
// Shared definitions for the sequence-increment checker.
// Provides the checker state encoding and the default parameter values
// used by seq_incr_checker and seq_chk_timer.
package seq_chk_pkg;

  localparam int DEF_WIDTH        = 4;
  localparam int DEF_TARGET_COUNT = 4;
  localparam int DEF_TIMEOUT      = 16;
  localparam int DEF_ERRW         = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_CHECK = 3'd2,
    S_PASS  = 3'd3,
    S_FAIL  = 3'd4
  } state_e;

  // A run is in progress: waiting for a baseline or checking increments.
  function automatic logic state_is_busy(state_e s);
    return (s == S_ARMED) || (s == S_CHECK);
  endfunction

  // A verdict has been reached and is being held.
  function automatic logic state_is_done(state_e s);
    return (s == S_PASS) || (s == S_FAIL);
  endfunction

endpackage

// File: rtl/seq_chk_timer.sv
// Stall timer: counts idle cycles between valid samples, clearable.
// Latency: count updates on the clock edge; expire_o is a decode of the register.
// Ports: clk/rst (sync active-high), clr_i restart at zero, en_i count one idle
//        cycle, expire_o high once TIMEOUT-1 idle cycles have been counted.
module seq_chk_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Clear has priority over counting; the count parks at LAST so it can
  // never wrap back to zero and hide a stall.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/seq_incr_checker.sv
// Consumer of an incrementing value stream: checks each sample is the previous
// one plus one, counts correct increments, detects stalls, and latches a single
// PASS/FAIL verdict.
// Ports: clk/rst (sync active-high); start arms the checker from IDLE/PASS/FAIL;
//   in_valid/in_value carry samples; expected = next required value;
//   incr_count/err_count = progress counters; busy/done/pass/fail = status.
// Build option: define SEQ_CHK_WRAP_EN to accept all-ones -> 0 as a correct
//   increment; left undefined, any sample following all-ones is an error.
module seq_incr_checker
  import seq_chk_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int TARGET_COUNT = DEF_TARGET_COUNT,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int ERRW         = DEF_ERRW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] incr_count,
  output logic [ERRW-1:0]  err_count,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  localparam logic [WIDTH-1:0] TARGET_W = WIDTH'(TARGET_COUNT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [WIDTH-1:0] incr_q, incr_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic             busy_q, done_q, pass_q, fail_q;

  logic             tmr_clr, tmr_en, tmr_expire;
  logic             wrap_block;
  logic             sample_ok;

  seq_chk_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

`ifdef SEQ_CHK_WRAP_EN
  assign wrap_block = 1'b0;
`else
  // In CHECK, expected can only be zero when the previous sample was
  // all-ones, i.e. the required increment would wrap.
  assign wrap_block = (expected_q == '0);
`endif

  assign sample_ok = (in_value == expected_q) && !wrap_block;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    incr_d     = incr_q;
    err_d      = err_q;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;

    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        // A sample arriving with start is deliberately not captured.
        if (start) begin
          state_d    = S_ARMED;
          expected_d = '0;
          incr_d     = '0;
          err_d      = '0;
          tmr_clr    = 1'b1;
        end
      end

      S_ARMED: begin
        if (in_valid) begin
          // Baseline sample: nothing to compare against yet.
          expected_d = in_value + 1'b1;
          tmr_clr    = 1'b1;
          state_d    = S_CHECK;
        end else if (tmr_expire) begin
          state_d = S_FAIL;
        end else begin
          tmr_en = 1'b1;
        end
      end

      S_CHECK: begin
        if (in_valid) begin
          // A valid sample always wins over a coincident timeout.
          tmr_clr = 1'b1;
          if (sample_ok) begin
            incr_d     = incr_q + 1'b1;
            expected_d = expected_q + 1'b1;
            if (incr_d == TARGET_W) begin
              state_d = S_PASS;
            end
          end else begin
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
            expected_d = in_value + 1'b1;
            state_d    = S_FAIL;
          end
        end else if (tmr_expire) begin
          state_d = S_FAIL;
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      expected_q <= '0;
      incr_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      incr_q     <= incr_d;
      err_q      <= err_d;
      // Status flags are registered from the next state so they line up
      // exactly with state_q without an output decode.
      busy_q     <= state_is_busy(state_d);
      done_q     <= state_is_done(state_d);
      pass_q     <= (state_d == S_PASS);
      fail_q     <= (state_d == S_FAIL);
    end
  end

  assign expected   = expected_q;
  assign incr_count = incr_q;
  assign err_count  = err_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;

endmodule

// File: tb/tb_seq_incr_checker.sv
// Bench for seq_incr_checker: directed scenarios followed by random streams,
// every cycle compared against a behavioural model of the checker's rules.
module tb_seq_incr_checker;

  localparam int WIDTH   = 4;
  localparam int TARGET  = 4;
  localparam int TIMEOUT = 16;
  localparam int ERRW    = 4;
  localparam int M       = 1 << WIDTH;
`ifdef SEQ_CHK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, in_valid;
  logic [WIDTH-1:0] in_value;
  logic [WIDTH-1:0] expected, incr_count;
  logic [ERRW-1:0]  err_count;
  logic             busy, done, pass, fail;

  seq_incr_checker #(
    .WIDTH        (WIDTH),
    .TARGET_COUNT (TARGET),
    .TIMEOUT      (TIMEOUT),
    .ERRW         (ERRW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_value   (in_value),
    .expected   (expected),
    .incr_count (incr_count),
    .err_count  (err_count),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a run is active or not, has a baseline or not, and
  // carries a verdict (0 none, 1 pass, 2 fail).
  int m_active, m_base, m_verdict, m_prev, m_incr, m_err, m_gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit v, input int val);
    if (r) begin
      m_active = 0; m_base = 0; m_verdict = 0;
      m_prev = 0; m_incr = 0; m_err = 0; m_gap = 0;
    end else if (m_active == 0) begin
      if (s) begin
        m_active = 1; m_base = 0; m_verdict = 0;
        m_incr = 0; m_err = 0; m_gap = 0;
      end
    end else if (v) begin
      m_gap = 0;
      if (m_base == 0) begin
        m_base = 1;
        m_prev = val;
      end else begin
        bit ok;
        if (WRAP) ok = (val == (m_prev + 1) % M);
        else      ok = (m_prev + 1 < M) && (val == m_prev + 1);
        m_prev = val;
        if (ok) begin
          m_incr++;
          if (m_incr == TARGET) begin m_active = 0; m_verdict = 1; end
        end else begin
          if (m_err < (1 << ERRW) - 1) m_err++;
          m_active = 0; m_verdict = 2;
        end
      end
    end else begin
      // The TIMEOUT-th consecutive cycle without a sample ends the run.
      m_gap++;
      if (m_gap == TIMEOUT) begin m_active = 0; m_verdict = 2; end
    end
  endtask

  task automatic check_all();
    chk("expected", expected, (m_base != 0) ? (m_prev + 1) % M : 0);
    chk("incr_count", incr_count, m_incr);
    chk("err_count", err_count, m_err);
    chk("busy", busy, m_active);
    chk("done", done, m_verdict != 0);
    chk("pass", pass, m_verdict == 1);
    chk("fail", fail, m_verdict == 2);
  endtask

  task automatic cyc(input bit r, input bit s, input bit v, input int val);
    rst      = r;
    start    = s;
    in_valid = v;
    in_value = WIDTH'(val);
    @(posedge clk);
    model_step(r, s, v, val);
    #1;
    check_all();
  endtask

  int quiet   = 0;
  int cnt_val = 0;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_value = '0;

    // Reset
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_expected", expected, 0);
    chk("rst_done", done, 0);

    // Clean stream 0..4 passes
    cyc(0, 1, 0, 0);
    for (int k = 0; k <= 4; k++) cyc(0, 0, 1, k);
    chk("plan_pass", pass, 1);
    chk("plan_incr", incr_count, 4);
    chk("plan_err", err_count, 0);

    // Skipped value fails and resynchronises
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 3);
    cyc(0, 0, 1, 4);
    cyc(0, 0, 1, 6);
    chk("mis_fail", fail, 1);
    chk("mis_pass", pass, 0);
    chk("mis_err", err_count, 1);
    chk("mis_expected", expected, 7);

    // Stall of 16 cycles after the baseline times out
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 5);
    repeat (15) cyc(0, 0, 0, 0);
    chk("to_not_yet", fail, 0);
    cyc(0, 0, 0, 0);
    chk("to_fail", fail, 1);

    // Gap of 15 cycles then the right value survives
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 5);
    repeat (15) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 6);
    chk("gap_busy", busy, 1);
    chk("gap_incr", incr_count, 1);

    // Wrap through all-ones
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 14);
    cyc(0, 0, 1, 15);
    cyc(0, 0, 1, 0);
    chk("wrap_at_zero_fail", fail, WRAP ? 0 : 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 2);
    chk("wrap_pass", pass, WRAP ? 1 : 0);
    chk("wrap_incr", incr_count, WRAP ? 4 : 1);

    // Mid-stream reset, then samples without start are ignored
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(1, 0, 0, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_incr", incr_count, 0);
    chk("mrst_expected", expected, 0);
    cyc(0, 0, 1, 2);
    chk("nostart_busy", busy, 0);
    chk("nostart_expected", expected, 0);

    // start with in_valid in IDLE arms only; next sample is the baseline
    cyc(0, 1, 1, 9);
    chk("arm_busy", busy, 1);
    cyc(0, 0, 1, 3);
    chk("arm_baseline", expected, 4);

    // Held start during CHECK is ignored; start in PASS rearms
    cyc(0, 1, 1, 4);
    cyc(0, 1, 1, 5);
    cyc(0, 1, 1, 6);
    cyc(0, 1, 1, 7);
    chk("held_start_pass", pass, 1);
    cyc(0, 1, 0, 0);
    chk("rearm_done", done, 0);
    chk("rearm_incr", incr_count, 0);
    chk("rearm_busy", busy, 1);

    // Random streams: mostly correct increments, occasional glitches,
    // idle bursts, random starts and rare resets.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, v;
      int val;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 9) == 0);
      if (quiet > 0) begin
        v = 1'b0;
        quiet--;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) == 0) quiet = $urandom_range(10, 20);
      end
      if ($urandom_range(0, 24) == 0) val = $urandom_range(0, M - 1);
      else                            val = cnt_val;
      if (v) cnt_val = (val + 1) % M;
      cyc(r, s, v, val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
